// File: rtl/wave_scheduler_if.sv
// Bundles the wave scheduler's control, generator and DAC-side signals.
// The master side (sequencer/testbench) drives controls and generator data;
// the slave side (wave_scheduler) drives enables, restarts and the DAC path.
interface wave_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int DIV_W   = 16
);
    logic [DIV_W-1:0]     div;
    logic                 run;
    logic                 burst;
    logic [1:0]           sel_req;
    logic                 sel_valid;
    logic                 sel_ack;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_en;
    logic [NUM_SRC-1:0]   src_clr;
    logic [7:0]           dac_out;
    logic                 dac_valid;
    logic                 frame_start;
    logic                 busy;
    logic [1:0]           active_sel;

    modport master (
        output div, run, burst, sel_req, sel_valid, src_data,
        input  sel_ack, src_en, src_clr, dac_out, dac_valid, frame_start, busy, active_sel
    );

    modport slave (
        input  div, run, burst, sel_req, sel_valid, src_data,
        output sel_ack, src_en, src_clr, dac_out, dac_valid, frame_start, busy, active_sel
    );
endinterface

// File: rtl/wave_scheduler.sv
// Sequences up to four waveform generators onto the shared 8-bit DAC.
// A sample-rate divider paces the active generator; source changes are
// deferred to frame boundaries so a displayed trace never mixes sources.
module wave_scheduler #(
    parameter int NUM_SRC   = 4,
    parameter int DIV_W     = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              reset,
    wave_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state, next_state;
    logic [DIV_W-1:0]   div_l;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   sample_cnt;
    logic               pend_valid;
    logic [1:0]         pend_sel;
    logic [1:0]         active_sel;
    logic [7:0]         dac_out;
    logic               dac_valid;
    logic               frame_start;

    logic               tick;
    logic               frame_end;
    logic               sel_legal;
    logic               pend_eff;
    logic [1:0]         clr_sel;
    logic [7:0]         cur_data;
    logic [NUM_SRC-1:0] src_en;
    logic [NUM_SRC-1:0] src_clr;
    logic               sel_ack;

    // Out-of-range selections are dropped without touching the pending slot.
    assign sel_legal = bus.sel_valid && (int'(bus.sel_req) < NUM_SRC);
    // A request arriving on the frame-end cycle counts toward that decision.
    assign pend_eff  = pend_valid || sel_legal;
    assign tick      = (state == RUN) && (div_cnt == div_l);
    assign frame_end = tick && (sample_cnt == CNT_W'(FRAME_LEN - 1));
    // The restart goes to the generator that is about to become active.
    assign clr_sel   = pend_valid ? pend_sel : active_sel;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode plus the cycle-exact strobes (enable, restart, ack).
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        sel_ack    = 1'b0;
        src_en     = '0;
        src_clr    = '0;
        case (state)
            IDLE: begin
                if (bus.run || bus.burst) next_state = PRIME;
            end
            PRIME: begin
                next_state = RUN;
                sel_ack    = pend_valid;
                for (int i = 0; i < NUM_SRC; i++) src_clr[i] = (clr_sel == 2'(i));
            end
            RUN: begin
                for (int i = 0; i < NUM_SRC; i++) src_en[i] = tick && (active_sel == 2'(i));
                if (frame_end) begin
                    if (pend_eff)     next_state = PRIME;
                    else if (bus.run) next_state = RUN;
                    else              next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Source mux: pick the active generator's byte out of the packed bus.
    always_comb begin
        cur_data = 8'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_sel == 2'(i)) cur_data = bus.src_data[8*i +: 8];
        end
    end

    // Datapath: pending selection, divider, sample counter and DAC capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_l       <= '0;
            div_cnt     <= '0;
            sample_cnt  <= '0;
            pend_valid  <= 1'b0;
            pend_sel    <= 2'd0;
            active_sel  <= 2'd0;
            dac_out     <= 8'd128;
            dac_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            dac_valid   <= 1'b0;
            frame_start <= 1'b0;

            // A fresh request always wins over the PRIME consuming the old one.
            if (sel_legal) begin
                pend_sel   <= bus.sel_req;
                pend_valid <= 1'b1;
            end else if (state == PRIME) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    dac_out <= 8'd128;
                end
                PRIME: begin
                    if (pend_valid) active_sel <= pend_sel;
                    div_l      <= bus.div;
                    div_cnt    <= '0;
                    sample_cnt <= '0;
                end
                RUN: begin
                    if (tick) begin
                        div_cnt     <= '0;
                        dac_out     <= cur_data;
                        dac_valid   <= 1'b1;
                        frame_start <= (sample_cnt == '0);
                        sample_cnt  <= sample_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.src_en      = src_en;
    assign bus.src_clr     = src_clr;
    assign bus.sel_ack     = sel_ack;
    assign bus.dac_out     = dac_out;
    assign bus.dac_valid   = dac_valid;
    assign bus.frame_start = frame_start;
    assign bus.busy        = (state != IDLE);
    assign bus.active_sel  = active_sel;
endmodule

// File: tb/tb_wave_scheduler.sv
// Directed bench for wave_scheduler: a latency/period table over several
// divider and source settings, then hand-written multi-cycle sequences.
module tb_wave_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;

    always #5 clk = ~clk;

    wave_scheduler_if #(.NUM_SRC(4), .DIV_W(16)) bus_a ();
    wave_scheduler_if #(.NUM_SRC(3), .DIV_W(16)) bus_b ();

    wave_scheduler #(.NUM_SRC(4), .DIV_W(16), .FRAME_LEN(256)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    wave_scheduler #(.NUM_SRC(3), .DIV_W(16), .FRAME_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    // Generator models: counters starting at 64*i, restarted by src_clr.
    logic [7:0] gen [4];
    always_ff @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)                gen[i] <= 8'(i * 64);
            else if (bus_a.src_clr[i]) gen[i] <= 8'(i * 64);
            else if (bus_a.src_en[i])  gen[i] <= gen[i] + 8'd1;
        end
    end
    assign bus_a.src_data = {gen[3], gen[2], gen[1], gen[0]};
    assign bus_b.src_data = {8'd30, 8'd20, 8'd10};

    // Strobe sanity: enable never with restart, never outside busy, one-hot.
    always @(negedge clk) begin
        if ((bus_a.src_en & bus_a.src_clr) != 0) viol++;
        if (bus_a.src_en != 0 && !bus_a.busy) viol++;
        if (!$onehot0(bus_a.src_en)) viol++;
        if ((bus_b.src_en & bus_b.src_clr) != 0) viol++;
        if (bus_b.src_en != 0 && !bus_b.busy) viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int div;
        int sel;
        int exp_clr;
        int exp_en;
        int exp_valid;
        int exp_period;
        int exp_d0;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.div = '0; bus_a.run = 1'b0; bus_a.burst = 1'b0;
        bus_a.sel_req = 2'd0; bus_a.sel_valid = 1'b0;
        bus_b.div = '0; bus_b.run = 1'b0; bus_b.burst = 1'b0;
        bus_b.sel_req = 2'd0; bus_b.sel_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        vec_t vecs [4];
        int first_en, en_val, v1, v2, d1, d2, fs1, fs2;
        int vk, bad, acks, clr_cnt, en_cnt, fs_cnt, post, ack_seen, done;
        int ack_vk, ack_clr, ack_en, g_valid, g_sel, g_en, p_valid, p_fs, p_data;
        int last_c, after_dac, after_busy, valid_cnt;
        logic [7:0] prev0;

        //          div sel clr  en valid period d0
        vecs[0] = '{0,  0,  1,   1, 2,    1,     0};
        vecs[1] = '{1,  1,  2,   2, 3,    2,     64};
        vecs[2] = '{3,  2,  4,   4, 5,    4,     128};
        vecs[3] = '{6,  3,  8,   7, 8,    7,     192};

        // Reset state.
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("rst_dac_out", bus_a.dac_out, 128);
        check("rst_busy", bus_a.busy, 0);
        check("rst_active_sel", bus_a.active_sel, 0);
        check("rst_dac_valid", bus_a.dac_valid, 0);
        check("rst_strobes", {bus_a.src_en, bus_a.src_clr, bus_a.sel_ack, bus_a.frame_start}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Latency / period table: selection made in IDLE, then run.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            bus_a.sel_req   = 2'(vecs[i].sel);
            bus_a.sel_valid = 1'b1;
            @(negedge clk);
            bus_a.sel_valid = 1'b0;
            bus_a.div       = 16'(vecs[i].div);
            bus_a.run       = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_prime_busy", i), bus_a.busy, 1);
            check($sformatf("v%0d_prime_clr", i), bus_a.src_clr, vecs[i].exp_clr);
            check($sformatf("v%0d_prime_ack", i), bus_a.sel_ack, 1);
            first_en = -1; en_val = 0; v1 = -1; v2 = -1; d1 = -1; d2 = -1; fs1 = -1; fs2 = -1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (bus_a.src_en != 0 && first_en < 0) begin
                    first_en = c;
                    en_val   = bus_a.src_en;
                end
                if (bus_a.dac_valid) begin
                    if (v1 < 0) begin
                        v1 = c; d1 = bus_a.dac_out; fs1 = bus_a.frame_start;
                    end else if (v2 < 0) begin
                        v2 = c; d2 = bus_a.dac_out; fs2 = bus_a.frame_start;
                    end
                end
            end
            check($sformatf("v%0d_first_en_cycle", i), first_en, vecs[i].exp_en);
            check($sformatf("v%0d_en_onehot", i), en_val, vecs[i].exp_clr);
            check($sformatf("v%0d_first_valid_cycle", i), v1, vecs[i].exp_valid);
            check($sformatf("v%0d_valid_period", i), v2 - v1, vecs[i].exp_period);
            check($sformatf("v%0d_data0", i), d1, vecs[i].exp_d0);
            check($sformatf("v%0d_data1", i), d2, vecs[i].exp_d0 + 1);
            check($sformatf("v%0d_fs0", i), fs1, 1);
            check($sformatf("v%0d_fs1", i), fs2, 0);
            check($sformatf("v%0d_active_sel", i), bus_a.active_sel, vecs[i].sel);
            check($sformatf("v%0d_busy", i), bus_a.busy, 1);
            bus_a.run = 1'b0;
        end

        // Continuous run at div=0 over two full frames: seamless, no restarts.
        do_reset();
        bus_a.run = 1'b1;
        @(negedge clk);
        prev0 = bus_a.src_data[7:0];
        vk = 0; bad = 0; clr_cnt = 0; en_cnt = 0; fs_cnt = 0;
        for (int c = 1; c <= 514; c++) begin
            @(negedge clk);
            if (bus_a.src_clr != 0) clr_cnt++;
            if (bus_a.src_en == 4'b0001) en_cnt++;
            if (bus_a.dac_valid) begin
                if (bus_a.dac_out != 8'(vk)) bad++;
                if (bus_a.dac_out != prev0) bad++;
                if (bus_a.frame_start != ((vk % 256) == 0)) bad++;
                if (bus_a.frame_start) fs_cnt++;
                vk++;
            end
            prev0 = bus_a.src_data[7:0];
        end
        check("cont_valid_count", vk, 513);
        check("cont_frame_starts", fs_cnt, 3);
        check("cont_data_errors", bad, 0);
        check("cont_no_restart", clr_cnt, 0);
        check("cont_en_every_cycle", en_cnt, 514);

        // Source switch requested mid-frame (last request wins) applies at frame end.
        do_reset();
        bus_a.run = 1'b1;
        @(negedge clk);
        vk = 0; bad = 0; acks = 0; post = 0; ack_seen = 0; done = 0;
        ack_vk = -1; ack_clr = -1; ack_en = -1;
        g_valid = -1; g_sel = -1; g_en = -1; p_valid = -1; p_fs = -1; p_data = -1;
        for (int c = 1; c <= 600 && done == 0; c++) begin
            @(negedge clk);
            bus_a.sel_valid = 1'b0;
            if (bus_a.sel_ack) acks++;
            if (ack_seen != 0) begin
                post++;
                if (post == 1) begin
                    g_valid = bus_a.dac_valid; g_sel = bus_a.active_sel; g_en = bus_a.src_en;
                end else begin
                    p_valid = bus_a.dac_valid; p_fs = bus_a.frame_start; p_data = bus_a.dac_out;
                    done = 1;
                end
            end else begin
                if (bus_a.sel_ack) begin
                    ack_seen = 1; ack_vk = vk; ack_clr = bus_a.src_clr; ack_en = bus_a.src_en;
                end
                if (bus_a.dac_valid) begin
                    if (bus_a.dac_out != 8'(vk)) bad++;
                    if (bus_a.active_sel != 2'd0) bad++;
                    vk++;
                    if (vk == 101) begin bus_a.sel_req = 2'd1; bus_a.sel_valid = 1'b1; end
                    if (vk == 151) begin bus_a.sel_req = 2'd2; bus_a.sel_valid = 1'b1; end
                end
            end
        end
        check("sw_done", done, 1);
        check("sw_old_frame_data", bad, 0);
        check("sw_ack_count", acks, 1);
        check("sw_ack_at_sample", ack_vk, 255);
        check("sw_prime_clr", ack_clr, 4);
        check("sw_prime_no_en", ack_en, 0);
        check("sw_gap_valid", g_valid, 0);
        check("sw_new_active", g_sel, 2);
        check("sw_new_en", g_en, 4);
        check("sw_first_valid", p_valid, 1);
        check("sw_first_fs", p_fs, 1);
        check("sw_first_data", p_data, 128);

        // Single burst frame at div=1; a second burst mid-frame is ignored.
        do_reset();
        bus_a.div   = 16'd1;
        bus_a.burst = 1'b1;
        @(negedge clk);
        bus_a.burst = 1'b0;
        vk = 0; fs_cnt = 0; last_c = -1; after_dac = -1; after_busy = -1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            bus_a.burst = 1'b0;
            if (c == last_c + 1 && last_c > 0) begin
                after_dac = bus_a.dac_out; after_busy = bus_a.busy;
            end
            if (bus_a.dac_valid) begin
                vk++;
                if (bus_a.frame_start) fs_cnt++;
                if (vk == 100) bus_a.burst = 1'b1;
                if (vk == 256) last_c = c;
            end
        end
        check("burst_valid_count", vk, 256);
        check("burst_frame_starts", fs_cnt, 1);
        check("burst_dac_after_last", after_dac, 128);
        check("burst_busy_after_last", after_busy, 0);
        check("burst_end_busy", bus_a.busy, 0);
        check("burst_end_dac", bus_a.dac_out, 128);

        // Out-of-range selection on a 3-source instance, then a legal one.
        do_reset();
        bus_b.run = 1'b1;
        repeat (10) @(negedge clk);
        bus_b.sel_req = 2'd3; bus_b.sel_valid = 1'b1;
        acks = 0; clr_cnt = 0; valid_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus_b.sel_valid = 1'b0;
            if (bus_b.sel_ack) acks++;
            if (bus_b.src_clr != 0) clr_cnt++;
            if (bus_b.dac_valid) valid_cnt++;
        end
        check("bad_sel_acks", acks, 0);
        check("bad_sel_no_prime", clr_cnt, 0);
        check("bad_sel_continuous", valid_cnt, 20);
        check("bad_sel_active", bus_b.active_sel, 0);
        check("bad_sel_data", bus_b.dac_out, 10);
        bus_b.sel_req = 2'd2; bus_b.sel_valid = 1'b1;
        acks = 0; clr_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus_b.sel_valid = 1'b0;
            if (bus_b.sel_ack) acks++;
            if (bus_b.src_clr == 3'b100) clr_cnt++;
        end
        check("good_sel_acks", acks, 1);
        check("good_sel_clr", clr_cnt, 1);
        check("good_sel_active", bus_b.active_sel, 2);
        check("good_sel_data", bus_b.dac_out, 30);
        bus_b.run = 1'b0;

        // Asynchronous reset at sample 50, then a clean restart.
        do_reset();
        bus_a.run = 1'b1;
        @(negedge clk);
        vk = 0;
        for (int c = 0; c < 100 && vk < 51; c++) begin
            @(negedge clk);
            if (bus_a.dac_valid) vk++;
        end
        check("mid_reset_reached_50", vk, 51);
        reset = 1'b1;
        #1;
        check("mid_reset_dac", bus_a.dac_out, 128);
        check("mid_reset_busy", bus_a.busy, 0);
        check("mid_reset_valid", bus_a.dac_valid, 0);
        check("mid_reset_en", bus_a.src_en, 0);
        bus_a.run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        valid_cnt = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_a.dac_valid) valid_cnt++;
            if (bus_a.busy) bad++;
        end
        check("post_reset_quiet_valid", valid_cnt, 0);
        check("post_reset_quiet_busy", bad, 0);
        bus_a.run = 1'b1;
        @(negedge clk);
        check("restart_prime_clr", bus_a.src_clr, 1);
        p_valid = 0; p_fs = -1; p_data = -1;
        for (int c = 0; c < 10 && p_valid == 0; c++) begin
            @(negedge clk);
            if (bus_a.dac_valid) begin
                p_valid = 1; p_fs = bus_a.frame_start; p_data = bus_a.dac_out;
            end
        end
        check("restart_valid", p_valid, 1);
        check("restart_fs", p_fs, 1);
        check("restart_data", p_data, 0);
        bus_a.run = 1'b0;
        repeat (2) @(negedge clk);

        check("strobe_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
